led7seg_capture: RTL

// - Receive side of the multiplexed 7-seg interface: samples an active-low segment bus plus an active-low anode select and recovers the hex digit shown on each of 4 positions.
// - Sits on the board/bench side of the display driver; used for self-check, loopback and display sniffing.
// - Outputs a registered digit array with per-digit valid bits and a one-cycle update strobe.

---
 rtl/led7seg_capture.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/led7seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : led7seg_capture
// Recovers the 4 hex digits shown on a multiplexed active-low 7-seg bus.
// Optional error counter (err_cnt/err_clr) when LED7CAP_ERR_CNT_EN is defined.
// Revision : 1.0
// ============================================================================
module led7seg_capture #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg_in,
   input  logic [3:0]  an_in,
`ifdef LED7CAP_ERR_CNT_EN
   input  logic        err_clr,
   output logic [7:0]  err_cnt,
`endif
   output logic [15:0] digits,
   output logic [3:0]  digit_valid,
   output logic        upd,
   output logic [1:0]  upd_idx,
   output logic        pat_err
);

   localparam logic [1:0] c_ST_IDLE   = 2'd0;
   localparam logic [1:0] c_ST_SETTLE = 2'd1;
   localparam logic [1:0] c_ST_HOLD   = 2'd2;
   localparam logic [7:0] c_STABLE    = 8'(STABLE_CYCLES);

   logic [6:0]  seg_s1_q, seg_s2_q, ref_seg_q, ref_seg_d;
   logic [3:0]  an_s1_q, an_s2_q, ref_an_q, ref_an_d;
   logic [1:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] digits_q, digits_d;
   logic [3:0]  valid_q, valid_d;
   logic        upd_q, upd_d, pat_err_q, pat_err_d;
   logic [1:0]  upd_idx_q, upd_idx_d;
   logic        w_onehot, w_same, w_capture;
   logic [1:0]  w_cap_idx;
   logic [3:0]  w_dec_val;
   logic        w_dec_ok, w_dec_blank;

   // Idle bus is all-ones, so the synchronisers reset to that value.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_s1_q  <= '1;
         an_s2_q  <= '1;
         seg_s1_q <= '1;
         seg_s2_q <= '1;
      end else begin
         an_s1_q  <= an_in;
         an_s2_q  <= an_s1_q;
         seg_s1_q <= seg_in;
         seg_s2_q <= seg_s1_q;
      end
   end

   always_comb begin
      case (an_s2_q)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: w_onehot = 1'b1;
         default:                            w_onehot = 1'b0;
      endcase
   end

   // ref_* holds the sample the current stable run is made of.
   assign w_same    = ({an_s2_q, seg_s2_q} == {ref_an_q, ref_seg_q});
   assign w_capture = (state_q == c_ST_SETTLE) && (cnt_q == c_STABLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= c_ST_IDLE;
         cnt_q     <= '0;
         ref_an_q  <= '1;
         ref_seg_q <= '1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ref_an_q  <= ref_an_d;
         ref_seg_q <= ref_seg_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ref_an_d  = ref_an_q;
      ref_seg_d = ref_seg_q;
      if (((state_q != c_ST_SETTLE) && (state_q != c_ST_HOLD)) || !w_same) begin
         ref_an_d  = an_s2_q;
         ref_seg_d = seg_s2_q;
         if (w_onehot) begin
            state_d = c_ST_SETTLE;
            cnt_d   = 8'd1;
         end else begin
            state_d = c_ST_IDLE;
            cnt_d   = '0;
         end
      end else if (state_q == c_ST_SETTLE) begin
         if (cnt_q == c_STABLE) state_d = c_ST_HOLD;
         else                   cnt_d   = cnt_q + 8'd1;
      end
   end

   always_comb begin
      case (ref_an_q)
         4'b1101: w_cap_idx = 2'd1;
         4'b1011: w_cap_idx = 2'd2;
         4'b0111: w_cap_idx = 2'd3;
         default: w_cap_idx = 2'd0;
      endcase
   end

   always_comb begin
      w_dec_ok    = 1'b1;
      w_dec_blank = 1'b0;
      w_dec_val   = 4'h0;
      case (ref_seg_q)
         7'h40: w_dec_val = 4'h0;
         7'h79: w_dec_val = 4'h1;
         7'h24: w_dec_val = 4'h2;
         7'h30: w_dec_val = 4'h3;
         7'h19: w_dec_val = 4'h4;
         7'h12: w_dec_val = 4'h5;
         7'h02: w_dec_val = 4'h6;
         7'h78: w_dec_val = 4'h7;
         7'h00: w_dec_val = 4'h8;
         7'h10: w_dec_val = 4'h9;
         7'h08: w_dec_val = 4'hA;
         7'h03: w_dec_val = 4'hB;
         7'h46: w_dec_val = 4'hC;
         7'h21: w_dec_val = 4'hD;
         7'h06: w_dec_val = 4'hE;
         7'h0E: w_dec_val = 4'hF;
         7'h7F: begin
            w_dec_ok    = 1'b0;
            w_dec_blank = 1'b1;
         end
         default: w_dec_ok = 1'b0;
      endcase
   end

   // upd only fires when the stored state really changes.
   always_comb begin
      digits_d  = digits_q;
      valid_d   = valid_q;
      upd_d     = 1'b0;
      upd_idx_d = upd_idx_q;
      pat_err_d = 1'b0;
      if (w_capture) begin
         if (w_dec_ok) begin
            if (!valid_q[w_cap_idx] || (digits_q[{w_cap_idx, 2'b00} +: 4] != w_dec_val)) begin
               digits_d[{w_cap_idx, 2'b00} +: 4] = w_dec_val;
               valid_d[w_cap_idx]                = 1'b1;
               upd_d                             = 1'b1;
               upd_idx_d                         = w_cap_idx;
            end
         end else if (w_dec_blank) begin
            if (valid_q[w_cap_idx]) begin
               valid_d[w_cap_idx] = 1'b0;
               upd_d              = 1'b1;
               upd_idx_d          = w_cap_idx;
            end
         end else begin
            pat_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digits_q  <= '0;
         valid_q   <= '0;
         upd_q     <= 1'b0;
         upd_idx_q <= '0;
         pat_err_q <= 1'b0;
      end else begin
         digits_q  <= digits_d;
         valid_q   <= valid_d;
         upd_q     <= upd_d;
         upd_idx_q <= upd_idx_d;
         pat_err_q <= pat_err_d;
      end
   end

   assign digits      = digits_q;
   assign digit_valid = valid_q;
   assign upd         = upd_q;
   assign upd_idx     = upd_idx_q;
   assign pat_err     = pat_err_q;

`ifdef LED7CAP_ERR_CNT_EN
   logic       w_ref_multi, w_multi_entry;
   logic [8:0] w_err_sum;
   logic [7:0] err_cnt_q;

   // In IDLE ref_an_q is last cycle's anode sample, so this flags multi-hot -> one-hot.
   assign w_ref_multi   = (ref_an_q != 4'hF) && ($countones(ref_an_q) <= 2);
   assign w_multi_entry = (state_q == c_ST_IDLE) && w_onehot && w_ref_multi;
   assign w_err_sum     = {1'b0, err_cnt_q} + {8'd0, pat_err_q} + {8'd0, w_multi_entry};

   always_ff @(posedge clk) begin
      if (rst || err_clr)          err_cnt_q <= '0;
      else if (w_err_sum > 9'd255) err_cnt_q <= 8'hFF;
      else                         err_cnt_q <= w_err_sum[7:0];
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire
